// File: rtl/traffic_fair_arbiter.sv
// Fair round-robin traffic-light controller: ALL_RED -> GREEN -> YELLOW per served direction,
// with minimum/maximum green, fixed yellow and minimum all-red clearance.
module traffic_fair_arbiter #(
    parameter int unsigned N_DIR     = 3,
    parameter int unsigned GREEN_MIN = 4,
    parameter int unsigned GREEN_MAX = 8,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned RED_T     = 1,
    parameter int unsigned TIMER_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_DIR-1:0]         req,
    output logic [N_DIR-1:0]         green,
    output logic [N_DIR-1:0]         yellow,
    output logic                     all_red,
    output logic [$clog2(N_DIR)-1:0] cur_dir,
    output logic                     phase_done
);

    localparam int unsigned DIR_W = $clog2(N_DIR);

    localparam logic [TIMER_W-1:0] GreenMinLast = TIMER_W'(GREEN_MIN - 1);
    localparam logic [TIMER_W-1:0] GreenMaxLast = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] YellowLast   = TIMER_W'(YELLOW_T - 1);
    localparam logic [TIMER_W-1:0] RedLast      = TIMER_W'(RED_T - 1);

    typedef enum logic [1:0] {
        StAllRed,
        StGreen,
        StYellow
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
    logic               phase_done_q, phase_done_d;

    logic [N_DIR-1:0]   cur_mask;
    logic [DIR_W-1:0]   winner, win_hi, win_lo;
    logic               found_hi, found_lo;
    logic               others_req, own_req;

    // Circular scan from cur_dir+1: prefer the lowest requester above cur_dir, else wrap around.
    always_comb begin
        cur_mask = '0;
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < int'(N_DIR); i++) begin
            cur_mask[i] = (DIR_W'(i) == cur_dir_q);
            if (req[i] && (DIR_W'(i) > cur_dir_q) && !found_hi) begin
                win_hi   = DIR_W'(i);
                found_hi = 1'b1;
            end
            if (req[i] && (DIR_W'(i) <= cur_dir_q) && !found_lo) begin
                win_lo   = DIR_W'(i);
                found_lo = 1'b1;
            end
        end
        winner     = found_hi ? win_hi : win_lo;
        others_req = |(req & ~cur_mask);
        own_req    = |(req & cur_mask);
    end

    always_comb begin
        state_d      = state_q;
        cur_dir_d    = cur_dir_q;
        phase_done_d = 1'b0;
        case (state_q)
            StAllRed: begin
                if ((timer_q >= RedLast) && (|req)) begin
                    state_d   = StGreen;
                    cur_dir_d = winner;
                end
            end
            StGreen: begin
                // A lone requester keeps its green; contention only cuts it at GREEN_MAX.
                if ((timer_q >= GreenMinLast) &&
                    (!(|req) || (others_req && (!own_req || (timer_q >= GreenMaxLast))))) begin
                    state_d = StYellow;
                end
            end
            StYellow: begin
                if (timer_q == YellowLast) begin
                    state_d      = StAllRed;
                    phase_done_d = 1'b1;
                end
            end
            default: state_d = StAllRed;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == '1) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StAllRed;
            timer_q      <= '0;
            cur_dir_q    <= DIR_W'(N_DIR - 1);
            phase_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cur_dir_q    <= cur_dir_d;
            phase_done_q <= phase_done_d;
        end
    end

    always_comb begin
        green      = (state_q == StGreen)  ? cur_mask : '0;
        yellow     = (state_q == StYellow) ? cur_mask : '0;
        all_red    = (state_q == StAllRed);
        cur_dir    = cur_dir_q;
        phase_done = phase_done_q;
    end

endmodule

// File: tb/tb_traffic_fair_arbiter.sv
// Directed bench for traffic_fair_arbiter with default parameters: a vector table for the
// basic grant/min-green/max-green flow, then rotation, lone-requester and reset sequences.
module tb_traffic_fair_arbiter;

    logic       clk;
    logic       reset_n;
    logic [2:0] req;
    logic [2:0] green;
    logic [2:0] yellow;
    logic       all_red;
    logic [1:0] cur_dir;
    logic       phase_done;

    int n_total;
    int n_pass;
    int pd_count;

    typedef struct {
        logic [2:0] req;
        logic [2:0] g;
        logic [2:0] y;
        logic       ar;
        logic [1:0] cd;
        logic       pd;
    } vec_t;

    vec_t tbl[21];

    traffic_fair_arbiter #(
        .N_DIR    (3),
        .GREEN_MIN(4),
        .GREEN_MAX(8),
        .YELLOW_T (2),
        .RED_T    (1),
        .TIMER_W  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .green     (green),
        .yellow    (yellow),
        .all_red   (all_red),
        .cur_dir   (cur_dir),
        .phase_done(phase_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] eg, input logic [2:0] ey,
                         input logic ear, input logic [1:0] ecd, input logic epd);
        n_total++;
        if (green !== eg || yellow !== ey || all_red !== ear || cur_dir !== ecd ||
            phase_done !== epd) begin
            $display("FAIL %s: got g=%b y=%b ar=%b cd=%0d pd=%b, want g=%b y=%b ar=%b cd=%0d pd=%b",
                     name, green, yellow, all_red, cur_dir, phase_done, eg, ey, ear, ecd, epd);
        end else begin
            n_pass++;
        end
    endtask

    // Drive req, take one rising edge, sample just after it.
    task automatic apply(input logic [2:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] eg, ey;
        logic       ear, epd;
        logic [1:0] ecd;
        int         pos, d;

        n_total  = 0;
        n_pass   = 0;
        pd_count = 0;
        reset_n  = 1'b0;
        req      = 3'b000;

        // req, green, yellow, all_red, cur_dir, phase_done (after the edge)
        tbl[0]  = '{3'b001, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{3'b000, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{3'b000, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[3]  = '{3'b000, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[4]  = '{3'b000, 3'b000, 3'b001, 1'b0, 2'd0, 1'b0};
        tbl[5]  = '{3'b000, 3'b000, 3'b001, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 1'b1};
        tbl[7]  = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{3'b000, 3'b000, 3'b000, 1'b1, 2'd0, 1'b0};
        tbl[9]  = '{3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[10] = '{3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[11] = '{3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{3'b010, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[14] = '{3'b011, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[15] = '{3'b011, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[16] = '{3'b011, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[17] = '{3'b011, 3'b000, 3'b010, 1'b0, 2'd1, 1'b0};
        tbl[18] = '{3'b011, 3'b000, 3'b010, 1'b0, 2'd1, 1'b0};
        tbl[19] = '{3'b011, 3'b000, 3'b000, 1'b1, 2'd1, 1'b1};
        tbl[20] = '{3'b011, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};

        #12;
        check("reset_state", 3'b000, 3'b000, 1'b1, 2'd2, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].req);
            check($sformatf("tbl[%0d]", i), tbl[i].g, tbl[i].y, tbl[i].ar, tbl[i].cd, tbl[i].pd);
        end

        // All three requesting: 8 green, 2 yellow, 1 all-red, rotating 0,1,2,0.
        for (int k = 1; k <= 33; k++) begin
            apply(3'b111);
            pos = k % 11;
            d   = (k / 11) % 3;
            eg  = 3'b000;
            ey  = 3'b000;
            ear = 1'b0;
            epd = 1'b0;
            ecd = 2'(d);
            if (pos < 8) begin
                eg = 3'(1 << d);
            end else if (pos < 10) begin
                ey = 3'(1 << d);
            end else begin
                ear = 1'b1;
                epd = 1'b1;
            end
            if (phase_done === 1'b1) pd_count++;
            check($sformatf("rotate k=%0d", k), eg, ey, ear, ecd, epd);
        end
        n_total++;
        if (pd_count != 3) begin
            $display("FAIL rotate_pd_count: got %0d, want 3", pd_count);
        end else begin
            n_pass++;
        end

        // Lone requester keeps green; 258 cycles would wrap an unsaturated 8-bit timer to 2.
        for (int j = 1; j <= 258; j++) begin
            apply(3'b001);
            check($sformatf("lone j=%0d", j), 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);
        end
        apply(3'b011);
        check("saturated_to_yellow", 3'b000, 3'b001, 1'b0, 2'd0, 1'b0);
        apply(3'b011);
        check("sat_yellow2", 3'b000, 3'b001, 1'b0, 2'd0, 1'b0);
        apply(3'b011);
        check("sat_allred", 3'b000, 3'b000, 1'b1, 2'd0, 1'b1);

        // Bring dir2 to yellow, then reset mid-yellow.
        apply(3'b100);
        check("dir2_green", 3'b100, 3'b000, 1'b0, 2'd2, 1'b0);
        for (int j = 1; j <= 3; j++) begin
            apply(3'b000);
            check($sformatf("dir2_min_green %0d", j), 3'b100, 3'b000, 1'b0, 2'd2, 1'b0);
        end
        apply(3'b000);
        check("dir2_yellow", 3'b000, 3'b100, 1'b0, 2'd2, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_abort_yellow", 3'b000, 3'b000, 1'b1, 2'd2, 1'b0);
        req = 3'b101;
        @(negedge clk);
        check("reset_held", 3'b000, 3'b000, 1'b1, 2'd2, 1'b0);
        reset_n = 1'b1;
        #1;
        check("release_no_step", 3'b000, 3'b000, 1'b1, 2'd2, 1'b0);
        apply(3'b101);
        check("post_reset_grant", 3'b001, 3'b000, 1'b0, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_fair_arbiter.md
TRAFFIC_FAIR_ARBITER -- requirements
Module: traffic_fair_arbiter

Interface
REQ-001 SHALL provide parameter N_DIR, default 3, number of approach directions (N_DIR >= 2).
REQ-002 SHALL provide parameter GREEN_MIN, default 4, minimum green cycles (>= 1).
REQ-003 SHALL provide parameter GREEN_MAX, default 8, maximum green cycles when contested (>= GREEN_MIN).
REQ-004 SHALL provide parameter YELLOW_T, default 2, yellow cycles (>= 1).
REQ-005 SHALL provide parameter RED_T, default 1, minimum all-red clearance cycles (>= 1).
REQ-006 SHALL provide parameter TIMER_W, default 8, phase timer width; GREEN_MAX, YELLOW_T and RED_T each SHALL be <= 2^TIMER_W.
REQ-007 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-008 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port: req  input  N_DIR  per-direction vehicle-present request, level-sensitive.
REQ-010 SHALL have port: green  output  N_DIR  one-hot or zero; green lamp per direction.
REQ-011 SHALL have port: yellow  output  N_DIR  one-hot or zero; yellow lamp per direction.
REQ-012 SHALL have port: all_red  output  1  high when no green or yellow is lit.
REQ-013 SHALL have port: cur_dir  output  $clog2(N_DIR)  index of direction currently or last served.
REQ-014 SHALL have port: phase_done  output  1  one-cycle pulse on the YELLOW->ALL_RED transition.

Function
REQ-015 SHALL implement a registered FSM with states ALL_RED, GREEN, YELLOW; all outputs are decoded from registered state only (Moore).
REQ-016 SHALL keep a TIMER_W-bit timer that clears to 0 on every state change and otherwise increments, saturating at 2^TIMER_W-1.
REQ-017 ALL_RED: all_red=1, green=0, yellow=0; SHALL move to GREEN when timer >= RED_T-1 and req != 0.
REQ-018 Winner SHALL be the first set bit of req scanned circularly from cur_dir+1 (mod N_DIR); cur_dir SHALL load the winner on the ALL_RED->GREEN edge.
REQ-019 GREEN: green[cur_dir]=1; SHALL move to YELLOW only when timer >= GREEN_MIN-1 and either (a) req == 0, or (b) some other direction requests and (req[cur_dir]==0 or timer >= GREEN_MAX-1).
REQ-020 When only req[cur_dir] is set, GREEN SHALL persist indefinitely (no forced yellow).
REQ-021 YELLOW: yellow[cur_dir]=1; SHALL move to ALL_RED when timer == YELLOW_T-1, asserting phase_done for that single transition cycle.
REQ-022 Request changes during YELLOW or ALL_RED SHALL not shorten either phase; a request arriving in YELLOW is arbitrated in the following ALL_RED.
REQ-023 green and yellow SHALL never both be nonzero; a direction SHALL never go GREEN without a preceding ALL_RED of at least RED_T cycles.
REQ-024 Fairness: a direction holding req continuously SHALL receive green before any other direction is granted twice.

Reset
REQ-025 While reset_n=0, SHALL asynchronously force state=ALL_RED, timer=0, cur_dir=N_DIR-1, green=0, yellow=0, all_red=1, phase_done=0.
REQ-026 Reset asserted mid-phase SHALL abort it immediately (lamps to all-red the same cycle); after release the first grant goes to the lowest-index requester.
REQ-027 Reset release SHALL be synchronous-deasserted externally; the block SHALL make no transition in the cycle reset_n rises.

Verification (N_DIR=3, GREEN_MIN=4, GREEN_MAX=8, YELLOW_T=2, RED_T=1)
REQ-028 Release reset with req=3'b001 -> green=001 on the first edge after release, cur_dir=0, all_red=0.
REQ-029 req=3'b111 held -> green sequence dir0,1,2,0,...; each green exactly 8 cycles, yellow 2, all-red 1; phase_done pulses once per 11-cycle period.
REQ-030 req=3'b001 held -> green=001 forever; yellow never asserts; timer saturates without wrap.
REQ-031 dir0 green, req drops to 000 at green cycle 1 -> green lasts 4 cycles total, then yellow=001 for 2, then all_red=1 steady.
REQ-032 dir1 green with req=3'b010, at green cycle 5 req becomes 3'b011 -> yellow=010 starts after green cycle 8 (GREEN_MAX); next green is dir0.
REQ-033 Assert reset_n=0 during yellow=100 -> yellow=0, all_red=1 same cycle; release with req=3'b101 -> next green=001.
